// File: rtl/decode_ctrl_if.sv
// IF -> decode_ctrl -> ID handshake bundle: fetch offer, flush, and presented instruction.
interface decode_ctrl_if;
  logic [31:0] inst_i;
  logic [31:0] pc_i;
  logic        valid_i;
  logic        ready_o;
  logic        flush_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic [2:0]  imm_sel_o;
  logic        illegal_o;
  logic        valid_o;
  logic        ready_i;

  modport slave (
    input  inst_i, pc_i, valid_i, flush_i, ready_i,
    output ready_o, inst_o, pc_o, imm_sel_o, illegal_o, valid_o
  );

  modport master (
    output inst_i, pc_i, valid_i, flush_i, ready_i,
    input  ready_o, inst_o, pc_o, imm_sel_o, illegal_o, valid_o
  );
endinterface

// File: rtl/decode_ctrl.sv
// Two-entry IF/ID skid buffer with opcode decode of the presented instruction.
module decode_ctrl #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  decode_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_e;

  state_e      state_q, state_d;
  logic        ready_q;
  logic        vld_p1;
  logic [31:0] main_inst_p1, main_pc_p1;
  logic [31:0] skid_inst_p1, skid_pc_p1;
  logic        in_xfer, out_xfer;
  logic        load_main_in, load_main_skid, load_skid;
  logic [3:0]  dec;

  // Returns {illegal, imm_sel} for a 7-bit opcode.
  function automatic logic [3:0] decode_op(input logic [6:0] op);
    logic [3:0] r;
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111,
      7'b1110011, 7'b0110011:              r = 4'b0_000;
      7'b0100011:                          r = 4'b0_001;
      7'b1100011:                          r = 4'b0_010;
      7'b1101111:                          r = 4'b0_011;
      7'b0110111, 7'b0010111:              r = 4'b0_100;
      default:                             r = 4'b1_000;
    endcase
    return r;
  endfunction

  assign in_xfer  = bus.valid_i & ready_q;
  assign out_xfer = vld_p1 & bus.ready_i;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (bus.flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_xfer) begin
          load_main_in = 1'b1;
          state_d      = FULL;
        end
        FULL: begin
          if (in_xfer && out_xfer) begin
            load_main_in = 1'b1;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end else if (in_xfer) begin
            load_skid = 1'b1;
            state_d   = SKID;
          end
        end
        SKID: if (out_xfer) begin
          load_main_skid = 1'b1;
          state_d        = FULL;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Control stage: state plus registered handshake flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      vld_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != SKID);
      vld_p1  <= (state_d != EMPTY);
    end
  end

  // Data stage: entries are qualified by vld_p1, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (load_main_in) begin
      main_inst_p1 <= bus.inst_i;
      main_pc_p1   <= bus.pc_i;
    end else if (load_main_skid) begin
      main_inst_p1 <= skid_inst_p1;
      main_pc_p1   <= skid_pc_p1;
    end
    if (load_skid) begin
      skid_inst_p1 <= bus.inst_i;
      skid_pc_p1   <= bus.pc_i;
    end
  end

  assign bus.ready_o   = ready_q;
  assign bus.valid_o   = vld_p1;
  assign bus.inst_o    = vld_p1 ? main_inst_p1 : NOP_INST;
  assign bus.pc_o      = vld_p1 ? main_pc_p1 : 32'h0;
  assign dec           = decode_op(bus.inst_o[6:0]);
  assign bus.imm_sel_o = dec[2:0];
  assign bus.illegal_o = dec[3];

endmodule

// File: tb/tb_decode_ctrl.sv
// Randomized scoreboard bench for decode_ctrl with directed streaming, backpressure, flush and reset cases.
module tb_decode_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [2:0]  imm;
    logic        ill;
  } item_t;

  logic clk = 1'b0;
  logic rst_ni;
  logic run = 1'b0;
  int   checks = 0;
  int   errors = 0;
  item_t q[$];

  decode_ctrl_if bus();

  decode_ctrl #(.NOP_INST(NOP)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end within time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode taken directly from the opcode table.
  function automatic item_t mk_item(input logic [31:0] inst, input logic [31:0] pc);
    item_t it;
    it.inst = inst;
    it.pc   = pc;
    it.ill  = 1'b0;
    it.imm  = 3'd0;
    if (inst[6:0] == 7'h23)                             it.imm = 3'd1;
    else if (inst[6:0] == 7'h63)                        it.imm = 3'd2;
    else if (inst[6:0] == 7'h6F)                        it.imm = 3'd3;
    else if (inst[6:0] == 7'h37 || inst[6:0] == 7'h17)  it.imm = 3'd4;
    else if (!(inst[6:0] inside {7'h03, 7'h13, 7'h67, 7'h73, 7'h33}))
      it.ill = 1'b1;
    return it;
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid_o"},   {31'b0, bus.valid_o},   32'd0);
    chk({tag, "_ready_o"},   {31'b0, bus.ready_o},   32'd1);
    chk({tag, "_inst_o"},    bus.inst_o,             NOP);
    chk({tag, "_pc_o"},      bus.pc_o,               32'd0);
    chk({tag, "_imm_sel_o"}, {29'b0, bus.imm_sel_o}, 32'd0);
    chk({tag, "_illegal_o"}, {31'b0, bus.illegal_o}, 32'd0);
  endtask

  // Monitor: buffer occupancy follows the model queue; head of queue must be presented.
  always @(negedge clk) begin
    if (run && rst_ni) begin
      chk("valid_o", {31'b0, bus.valid_o}, {31'b0, (q.size() > 0)});
      chk("ready_o", {31'b0, bus.ready_o}, {31'b0, (q.size() < 2)});
      if (q.size() == 0) begin
        chk("empty_inst_o", bus.inst_o, NOP);
        chk("empty_pc_o",   bus.pc_o,   32'd0);
        chk("empty_imm_ill", {28'b0, bus.illegal_o, bus.imm_sel_o}, 32'd0);
      end else begin
        chk("inst_o",    bus.inst_o,             q[0].inst);
        chk("pc_o",      bus.pc_o,               q[0].pc);
        chk("imm_sel_o", {29'b0, bus.imm_sel_o}, {29'b0, q[0].imm});
        chk("illegal_o", {31'b0, bus.illegal_o}, {31'b0, q[0].ill});
        if (bus.valid_o && bus.ready_i) void'(q.pop_front());
      end
    end
  end

  // One clock of stimulus; the model is updated after the monitor has seen this cycle.
  task automatic cycle(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic fl, input logic rdy);
    @(posedge clk);
    #2;
    bus.valid_i = v;
    bus.inst_i  = inst;
    bus.pc_i    = pc;
    bus.flush_i = fl;
    bus.ready_i = rdy;
    @(negedge clk);
    #1;
    if (rst_ni) begin
      if (fl) q.delete();
      else if (v && bus.ready_o) q.push_back(mk_item(inst, pc));
    end
  endtask

  task automatic reset_mid();
    @(posedge clk);
    #3;
    rst_ni = 1'b0;
    #1;
    chk_idle_outputs("midrst");
    q.delete();
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.ready_i = 1'b1;
    @(negedge clk);
    #2;
    rst_ni = 1'b1;
  endtask

  logic [6:0] ops [12] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h33, 7'h23,
                          7'h63, 7'h6F, 7'h37, 7'h17, 7'h00, 7'h7F};

  initial begin
    logic [31:0] r;
    logic [31:0] inst;
    logic [6:0]  op;
    bus.valid_i = 1'b0;
    bus.inst_i  = 32'h0;
    bus.pc_i    = 32'h0;
    bus.flush_i = 1'b0;
    bus.ready_i = 1'b0;
    rst_ni = 1'b1;
    #1 rst_ni = 1'b0;
    #1 chk_idle_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    run = 1'b1;

    // Streaming
    cycle(1'b1, 32'h00A00093, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 32'h00112223, 32'h4, 1'b0, 1'b1);
    cycle(1'b0, 32'hDEADBEEF, 32'hFC, 1'b0, 1'b1);
    cycle(1'b0, 32'hDEADBEEF, 32'hFC, 1'b0, 1'b1);

    // Backpressure into SKID, then drain in order
    cycle(1'b1, 32'h00208463, 32'h8, 1'b0, 1'b0);
    cycle(1'b1, 32'h0080006F, 32'hC, 1'b0, 1'b0);
    cycle(1'b1, 32'hBAD00033, 32'hEE, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Flush from SKID with a same-cycle offer
    cycle(1'b1, 32'h00000513, 32'h10, 1'b0, 1'b0);
    cycle(1'b1, 32'h00000593, 32'h14, 1'b0, 1'b0);
    cycle(1'b1, 32'h123450B7, 32'h18, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Illegal and U-type
    cycle(1'b1, 32'h00000000, 32'h20, 1'b0, 1'b1);
    cycle(1'b1, 32'h12345097, 32'h24, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Asynchronous reset while in SKID, then first accepted is first presented
    cycle(1'b1, 32'h00300113, 32'h30, 1'b0, 1'b0);
    cycle(1'b1, 32'h00400193, 32'h34, 1'b0, 1'b0);
    reset_mid();
    cycle(1'b1, 32'h00500213, 32'h40, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r  = $urandom();
      op = ops[$urandom_range(0, 11)];
      if ($urandom_range(0, 7) == 0) op = r[6:0];
      inst = {r[31:7], op};
      if (i == 250) reset_mid();
      cycle($urandom_range(0, 3) != 0, inst, {$urandom_range(0, 1023), 2'b00},
            $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0);
    end

    repeat (4) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("drained", q.size(), 32'd0);
    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_ctrl.md
DECODE_CTRL -- requirements
Module: decode_ctrl

Interface
REQ-001 The block SHALL have parameter NOP_INST, default 32'h0000_0013, the instruction value driven on inst_o whenever no instruction is held.
REQ-002 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_ni  input  1  reset; asynchronous and active-low.
REQ-004 inst_i  input  32  fetched instruction from IF.
REQ-005 pc_i  input  32  PC of inst_i.
REQ-006 valid_i  input  1  IF offers inst_i/pc_i this cycle.
REQ-007 ready_o  output  1  decode_ctrl accepts an offer this cycle.
REQ-008 flush_i  input  1  discard all held instructions (branch/jump redirect).
REQ-009 inst_o  output  32  instruction presented to ID datapath and immediate generator.
REQ-010 pc_o  output  32  PC of inst_o.
REQ-011 imm_sel_o  output  3  immediate format select for inst_o: 000 I, 001 S, 010 B, 011 J, 100 U.
REQ-012 illegal_o  output  1  inst_o opcode is not supported; qualified by valid_o.
REQ-013 valid_o  output  1  inst_o/pc_o/imm_sel_o/illegal_o are valid.
REQ-014 ready_i  input  1  downstream ID/EX accepts the presented instruction.

Function
REQ-015 The block SHALL be a 2-entry IF/ID buffer: a main entry (drives outputs) and a skid entry, with FSM states EMPTY, FULL (main only), SKID (main and skid).
REQ-016 Input transfer SHALL occur when valid_i && ready_o; output transfer SHALL occur when valid_o && ready_i.
REQ-017 ready_o SHALL be a registered output equal to 1 in EMPTY and FULL and 0 in SKID; it SHALL NOT depend combinationally on ready_i.
REQ-018 valid_o SHALL be 1 in FULL and SKID, 0 in EMPTY.
REQ-019 EMPTY: input transfer -> load main, go FULL; else stay.
REQ-020 FULL: in and out transfer -> load main with input, stay FULL; out only -> EMPTY; in only -> load skid, go SKID; neither -> hold.
REQ-021 SKID: out transfer -> move skid to main, go FULL; else hold both entries unchanged.
REQ-022 Latency SHALL be 1 cycle: an instruction accepted in cycle N appears on inst_o in cycle N+1 when the buffer was EMPTY or FULL with an output transfer.
REQ-023 Ordering SHALL be strictly FIFO; no instruction SHALL be dropped or duplicated except by flush_i.
REQ-024 imm_sel_o and illegal_o SHALL be decoded combinationally from inst_o[6:0]: 0000011, 0010011, 1100111, 1110011 -> 000; 0100011 -> 001; 1100011 -> 010; 1101111 -> 011; 0110111, 0010111 -> 100; 0110011 -> 000; any other opcode -> 000 with illegal_o=1.
REQ-025 When EMPTY, inst_o SHALL equal NOP_INST, pc_o SHALL equal 32'h0, imm_sel_o SHALL equal 000, illegal_o SHALL equal 0.
REQ-026 flush_i SHALL take priority over all transfers: next state EMPTY, both entries invalidated, any same-cycle input offer dropped, and ready_o equal to 1 the following cycle.
REQ-027 An output transfer in a flush cycle SHALL still count as consumed downstream; flush_i SHALL NOT cause re-presentation.
REQ-028 valid_i low SHALL leave state unchanged apart from output transfers; inst_i/pc_i SHALL be ignored when no input transfer occurs.

Reset
REQ-029 While rst_ni=0, state SHALL be EMPTY asynchronously: valid_o=0, ready_o=1, inst_o=NOP_INST, pc_o=0, imm_sel_o=000, illegal_o=0.
REQ-030 Reset asserted mid-operation SHALL discard both entries immediately; after deassertion the first accepted instruction SHALL be the first output.
REQ-031 Deassertion SHALL be sampled at the clock edge; the first input transfer is possible in the first cycle after rst_ni rises.

Verification
REQ-032 Streaming: ready_i=1, valid_i=1 with inst 32'h00A00093 (pc 0x0), 32'h00112223 (pc 0x4) on consecutive cycles -> inst_o shows them on cycles N+1, N+2 with imm_sel_o 000 then 001, valid_o=1, ready_o stays 1.
REQ-033 Backpressure: FULL with 32'h00208463 held, ready_i=0, offer 32'h0080006F -> ready_o=0 next cycle (SKID); raise ready_i -> outputs 010 then 011 in order, ready_o=1 after first output transfer.
REQ-034 Flush: SKID state, flush_i=1 with valid_i=1 offering 32'h123450B7 -> next cycle valid_o=0, inst_o=32'h00000013, ready_o=1; offered instruction never appears.
REQ-035 Illegal/U-type: present 32'h00000000 -> illegal_o=1, imm_sel_o=000; present 32'h12345097 -> imm_sel_o=100, illegal_o=0.
REQ-036 Async reset: pull rst_ni low between clock edges while in SKID -> outputs reach reset values before next edge; after release, first accepted instruction is the first presented.
